// File: rtl/pc_branch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_branch_sequencer
//
// Owns the program counter and resolves conditional branches. When a branch
// is decoded, the sign-extended immediate C (IR[OFF_BITS-1:0]) is captured.
// One cycle is spent letting the CON flip-flop settle. On the next cycle CON
// is sampled and PC either advances by the offset or is left unchanged.
//
// Ports:
//   clock     in   system clock, all state updates on the rising edge
//   reset_n   in   synchronous active-low reset
//   ir_in     in   instruction register contents (immediate field in low bits)
//   inc_req   in   fetch strobe, PC <= PC + 1 (only honoured while idle)
//   pc_load   in   unconditional load PC <= bus_in, aborts any branch
//   bus_in    in   value loaded by pc_load
//   br_start  in   one-cycle pulse: branch decoded (only accepted while idle)
//   con_in    in   CON flip-flop output, sampled in the EVAL cycle
//   pc_out    out  registered program counter
//   busy      out  branch resolution in progress (registered state decode)
//   br_done   out  one-cycle pulse: branch resolved
//   br_taken  out  outcome of the last resolved branch, held until next one
// ---------------------------------------------------------------------------
module pc_branch_sequencer #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}},
    parameter int unsigned      OFF_BITS = 19
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] ir_in,
    input  logic             inc_req,
    input  logic             pc_load,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             br_start,
    input  logic             con_in,
    output logic [WIDTH-1:0] pc_out,
    output logic             busy,
    output logic             br_done,
    output logic             br_taken
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_CON = 2'd1,
        S_EVAL     = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic        [WIDTH-1:0]  r_pc;
    logic signed [WIDTH-1:0]  r_off;
    logic                     r_br_done;
    logic                     r_br_taken;

    logic signed [WIDTH-1:0]  w_off_sext;
    logic                     w_unused_ir_hi;
    logic                     w_busy;
    logic                     w_idle;
    logic                     w_eval;
    logic                     w_eval_fire;
    logic                     w_inc_fire;
    logic                     w_capture;

    // Immediate field sign-extended from its top bit; the upper IR bits
    // belong to other instruction fields and are not used here.
    assign w_off_sext     = signed'({{(WIDTH-OFF_BITS){ir_in[OFF_BITS-1]}},
                                     ir_in[OFF_BITS-1:0]});
    assign w_unused_ir_hi = ^ir_in[WIDTH-1:OFF_BITS];

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic. pc_load wins over everything except reset and
    // drops any in-flight branch back to IDLE.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (pc_load) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     if (br_start) w_state_nxt = S_WAIT_CON;
                S_WAIT_CON: w_state_nxt = S_EVAL;
                S_EVAL:     w_state_nxt = S_IDLE;
                default:    w_state_nxt = S_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM: output decode. The *_fire strobes fold in the priority order so
    // the datapath below only has to look at one qualifier each.
    // -----------------------------------------------------------------------
    always_comb begin
        w_busy = 1'b0;
        w_idle = 1'b0;
        w_eval = 1'b0;
        case (r_state)
            S_IDLE:     w_idle = 1'b1;
            S_WAIT_CON: w_busy = 1'b1;
            S_EVAL: begin
                w_busy = 1'b1;
                w_eval = 1'b1;
            end
            default:    w_idle = 1'b1;
        endcase
        w_eval_fire = w_eval & ~pc_load;
        w_inc_fire  = w_idle & inc_req  & ~pc_load;
        w_capture   = w_idle & br_start & ~pc_load;
    end

    // -----------------------------------------------------------------------
    // PC / offset / result registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_pc       <= RESET_PC;
            r_off      <= '0;
            r_br_done  <= 1'b0;
            r_br_taken <= 1'b0;
        end else begin
            // Only EVAL raises br_done and EVAL always returns to IDLE, so
            // the pulse can never last more than one cycle.
            r_br_done <= w_eval_fire;

            if (pc_load) begin
                r_pc <= bus_in;
            end else if (w_eval_fire) begin
                if (con_in) begin
                    r_pc <= r_pc + $unsigned(r_off);
                end
            end else if (w_inc_fire) begin
                r_pc <= r_pc + {{(WIDTH-1){1'b0}}, 1'b1};
            end

            if (w_eval_fire) begin
                r_br_taken <= con_in;
            end

            // Capture happens alongside a same-cycle increment; the offset
            // is then applied to the incremented PC in EVAL.
            if (w_capture) begin
                r_off <= w_off_sext;
            end
        end
    end

    assign pc_out   = r_pc;
    assign busy     = w_busy;
    assign br_done  = r_br_done;
    assign br_taken = r_br_taken;

endmodule

// File: tb/tb_pc_branch_sequencer.sv
module tb_pc_branch_sequencer;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [W-1:0]  ir_in;
    logic          inc_req;
    logic          pc_load;
    logic [W-1:0]  bus_in;
    logic          br_start;
    logic          con_in;
    logic [W-1:0]  pc_out;
    logic          busy;
    logic          br_done;
    logic          br_taken;

    typedef struct {
        logic [W-1:0] pc;
        logic         taken;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_done = 1'b0;

    pc_branch_sequencer #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000),
        .OFF_BITS (19)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .ir_in    (ir_in),
        .inc_req  (inc_req),
        .pc_load  (pc_load),
        .bus_in   (bus_in),
        .br_start (br_start),
        .con_in   (con_in),
        .pc_out   (pc_out),
        .busy     (busy),
        .br_done  (br_done),
        .br_taken (br_taken)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_pc(input logic [W-1:0] v);
        pc_load = 1'b1;
        bus_in  = v;
        tick();
        pc_load = 1'b0;
    endtask

    // Issue a branch from IDLE, hold con_in through EVAL, and queue the
    // expected resolution for the monitor.
    task automatic branch(input logic [18:0] off, input logic con, input logic [W-1:0] exp_pc);
        exp_t e;
        ir_in    = {13'h0, off};
        br_start = 1'b1;
        tick();
        br_start = 1'b0;
        con_in   = con;
        tick();
        e.pc    = exp_pc;
        e.taken = con;
        exp_q.push_back(e);
        tick();
    endtask

    // Monitor: every br_done must match the oldest queued expectation.
    always @(negedge clock) begin
        if (br_done === 1'b1) begin
            check("br_done_single_cycle", {31'h0, prev_done}, 32'h0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_br_done: pc_out=%h br_taken=%b", pc_out, br_taken);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("branch_pc", pc_out, e.pc);
                check("branch_taken", {31'h0, br_taken}, {31'h0, e.taken});
            end
        end
        prev_done = (br_done === 1'b1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        ir_in    = '0;
        inc_req  = 1'b1;
        pc_load  = 1'b0;
        bus_in   = '0;
        br_start = 1'b0;
        con_in   = 1'b0;

        // Reset holds against inc_req
        tick();
        tick();
        check("rst_pc",       pc_out, 32'h0);
        check("rst_busy",     {31'h0, busy}, 32'h0);
        check("rst_br_done",  {31'h0, br_done}, 32'h0);
        check("rst_br_taken", {31'h0, br_taken}, 32'h0);
        reset_n = 1'b1;
        inc_req = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            inc_req = 1'b1;
            tick();
            inc_req = 1'b0;
            tick();
        end
        check("inc_three", pc_out, 32'h3);

        // Wrap
        load_pc(32'hFFFF_FFFF);
        check("load_all_ones", pc_out, 32'hFFFF_FFFF);
        inc_req = 1'b1;
        tick();
        inc_req = 1'b0;
        check("inc_wrap", pc_out, 32'h0);

        // Taken positive branch with latency checks
        load_pc(32'h10);
        ir_in    = {13'h0, 19'h00005};
        br_start = 1'b1;
        tick();
        br_start = 1'b0;
        check("busy_after_start", {31'h0, busy}, 32'h1);
        con_in = 1'b1;
        tick();
        check("pc_hold_in_eval", pc_out, 32'h10);
        check("no_done_early", {31'h0, br_done}, 32'h0);
        exp_q.push_back('{pc: 32'h15, taken: 1'b1});
        tick();
        check("pos_pc_direct", pc_out, 32'h15);
        check("busy_after_eval", {31'h0, busy}, 32'h0);
        tick();
        check("done_one_cycle", {31'h0, br_done}, 32'h0);

        // Taken negative, then not taken
        load_pc(32'h10);
        branch(19'h7FFFE, 1'b1, 32'h0E);
        load_pc(32'h10);
        branch(19'h7FFFE, 1'b0, 32'h10);
        check("not_taken_flag", {31'h0, br_taken}, 32'h0);

        // Back-to-back: second br_start in the cycle br_done is high
        load_pc(32'h10);
        branch(19'h00005, 1'b1, 32'h15);
        check("b2b_done_high", {31'h0, br_done}, 32'h1);
        branch(19'h00003, 1'b1, 32'h18);

        // Abort by pc_load in WAIT_CON: no br_done, br_taken holds (1)
        ir_in    = {13'h0, 19'h00007};
        br_start = 1'b1;
        tick();
        br_start = 1'b0;
        con_in   = 1'b1;
        load_pc(32'h200);
        check("abort_pc", pc_out, 32'h200);
        check("abort_busy", {31'h0, busy}, 32'h0);
        tick();
        tick();
        check("abort_pc_stable", pc_out, 32'h200);
        check("abort_taken_hold", {31'h0, br_taken}, 32'h1);

        // inc_req ignored while busy
        load_pc(32'h40);
        ir_in    = {13'h0, 19'h00002};
        br_start = 1'b1;
        tick();
        br_start = 1'b0;
        inc_req  = 1'b1;
        con_in   = 1'b0;
        tick();
        exp_q.push_back('{pc: 32'h40, taken: 1'b0});
        tick();
        inc_req = 1'b0;
        check("inc_ignored_busy", pc_out, 32'h40);

        // inc_req + br_start together: offset applied to incremented PC
        tick();
        ir_in    = {13'h0, 19'h00004};
        br_start = 1'b1;
        inc_req  = 1'b1;
        tick();
        br_start = 1'b0;
        inc_req  = 1'b0;
        check("inc_with_start", pc_out, 32'h41);
        con_in = 1'b1;
        tick();
        exp_q.push_back('{pc: 32'h45, taken: 1'b1});
        tick();
        tick();

        // Reset mid-branch during EVAL with con_in=1
        load_pc(32'h10);
        ir_in    = {13'h0, 19'h00005};
        br_start = 1'b1;
        tick();
        br_start = 1'b0;
        con_in   = 1'b1;
        tick();
        reset_n = 1'b0;
        tick();
        check("midrst_pc",       pc_out, 32'h0);
        check("midrst_br_done",  {31'h0, br_done}, 32'h0);
        check("midrst_br_taken", {31'h0, br_taken}, 32'h0);
        check("midrst_busy",     {31'h0, busy}, 32'h0);
        reset_n = 1'b1;
        con_in  = 1'b0;
        tick();
        tick();

        check("sb_drained", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_branch_sequencer.md
# pc_branch_sequencer

Owns the program counter and resolves conditional branches. It captures the branch offset when the control unit decodes a branch, then samples the CON flip-flop output once it has settled. It updates PC to PC + sign-extended offset when the condition holds and leaves PC unchanged otherwise. It sits directly downstream of the CON FF logic and feeds the PC register value onto the bus mux and the memory address path.

## Interface
- WIDTH, 32, datapath / PC width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- OFF_BITS, 19, width of the IR immediate field C (IR[18:0])

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- ir_in  in  WIDTH  current instruction register contents
- inc_req  in  1  fetch strobe: PC <= PC + 1
- pc_load  in  1  unconditional load of PC from bus_in (jr/jal)
- bus_in  in  WIDTH  bus value for pc_load
- br_start  in  1  one-cycle pulse: branch instruction decoded; CONin is asserted in the same cycle
- con_in  in  1  CON FF output
- pc_out  out  WIDTH  registered program counter
- busy  out  1  branch resolution in progress
- br_done  out  1  one-cycle pulse: branch resolved
- br_taken  out  1  result of last resolved branch, held until next br_done

## Operation
- FSM states: IDLE, WAIT_CON, EVAL.
- IDLE, br_start=1:
  - Capture off_reg <= sign-extend(ir_in[OFF_BITS-1:0]) to WIDTH, using bit OFF_BITS-1 as the sign.
  - Go to WAIT_CON.
- WAIT_CON: unconditionally go to EVAL. This is the one cycle for the CON FF to latch.
- EVAL:
  - Sample con_in.
  - If 1: pc <= pc + off_reg and br_taken <= 1. If 0: pc unchanged and br_taken <= 0.
  - br_done <= 1; go to IDLE.
- busy = 1 in WAIT_CON and EVAL, 0 in IDLE. busy is decoded from state, so it is registered.
- Arithmetic is modulo 2^WIDTH: PC + 1 and PC + offset wrap silently; no carry out.
- Priority within a cycle, highest first:
  - reset_n=0
  - pc_load (pc <= bus_in; FSM forced to IDLE, aborting any branch in progress; no br_done; br_taken holds)
  - EVAL update
  - inc_req
  - br_start
- inc_req is honoured only in IDLE; ignored in WAIT_CON/EVAL.
- br_start is ignored when not in IDLE.
- inc_req and br_start together in IDLE: PC increments and branch capture also occurs. The offset is applied later to the incremented PC.

## Timing
- Reset values (cycle after reset_n=0 sampled): pc_out=RESET_PC, state=IDLE, busy=0, br_done=0, br_taken=0, off_reg=0.
- Reset mid-branch aborts immediately: no br_done and no PC update.
- inc_req sampled at edge N: pc_out = old+1 visible after edge N.
- Branch latency, with br_start sampled at edge N:
  - busy=1 after N
  - EVAL during cycle N+1..N+2
  - con_in sampled at edge N+2
  - new pc_out and br_done=1 visible after N+2, for one cycle
  - busy=0 after N+2
- Back-to-back branches: br_start may be asserted in the cycle br_done is high. The FSM is in IDLE then, so it is accepted.
- br_done never asserts on consecutive cycles.

## Test plan
- Reset: drive reset_n=0 for 2 cycles with inc_req=1 -> pc_out=0, busy=0, br_done=0, br_taken=0; release, then 3 inc_req pulses -> pc_out=3.
- Wrap: pc_load with bus_in=32'hFFFF_FFFF, then inc_req -> pc_out=0.
- Taken positive branch: pc=0x10, ir_in[18:0]=19'h00005, br_start, con_in=1 at EVAL -> pc_out=0x15 two edges after br_start; br_done pulse 1 cycle; br_taken=1.
- Taken negative / not-taken: pc=0x10, ir_in[18:0]=19'h7FFFE, con_in=1 -> pc_out=0x0E. Repeat with con_in=0 -> pc_out stays 0x10, br_taken=0, br_done pulses.
- Abort by pc_load: br_start, then pc_load with bus_in=0x200 in WAIT_CON -> pc_out=0x200, busy=0 next cycle, no br_done; inc_req during busy has no effect.
- Reset mid-branch: br_start, then reset_n=0 during EVAL with con_in=1 -> pc_out=RESET_PC, no br_done, br_taken=0.
